// File: rtl/i2c_target_multi.sv
// i2c_target_multi: I2C target answering NUM_CH consecutive 7-bit addresses.
// Each address is a channel with its own DEPTH-byte bank and its own
// auto-incrementing pointer that persists across transactions.
//
// Ports:
//   clk_i, rst_i          system clock (>= 16x SCL), async active-high reset
//   scl_i, sda_i          raw bus lines (synchronised internally)
//   sda_oe_o              1 = pull SDA low
//   host_we_i/ch/addr/wdata  host-side bank preload
//   evt_valid_o + evt_*   one-cycle report per completed data byte
//   busy_o                1 between START and STOP
module i2c_target_multi #(
    parameter logic [6:0] BASE_ADDR = 7'h22,
    parameter int NUM_CH = 4,
    parameter int DEPTH = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe_o,
    input  logic             host_we_i,
    input  logic [CH_W-1:0]  host_ch_i,
    input  logic [PTR_W-1:0] host_addr_i,
    input  logic [7:0]       host_wdata_i,
    output logic             evt_valid_o,
    output logic             evt_rd_o,
    output logic [CH_W-1:0]  evt_ch_o,
    output logic [PTR_W-1:0] evt_addr_o,
    output logic [7:0]       evt_data_o,
    output logic             busy_o
);

    localparam logic [7:0] ADDR_LO  = {1'b0, BASE_ADDR};
    localparam logic [7:0] ADDR_END = 8'(int'(BASE_ADDR) + NUM_CH);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR_BYTE, DATA_ACK, WR_BYTE, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    // ---------------- input synchronisers + edge detect ----------------
    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;

    // Reset to the idle-bus level so reset release never looks like an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    logic scl, sda, scl_rise, scl_fall, start_det, stop_det;
    assign scl       = scl_sync[1];
    assign sda       = sda_sync[1];
    assign scl_rise  = scl & ~scl_d;
    assign scl_fall  = ~scl & scl_d;
    assign start_det = scl & scl_d & sda_d & ~sda;
    assign stop_det  = scl & scl_d & ~sda_d & sda;

    // ---------------- state ----------------
    state_t           state_q, state_d;
    logic             oe_q, oe_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       sh_q, sh_d;
    logic             ack_on_q, ack_on_d;   // ACK slot: 0 = waiting to drive, 1 = driving
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             rw_q, rw_d;
    logic [PTR_W-1:0] ptr_q [NUM_CH];
    logic [7:0]       bank [NUM_CH][DEPTH];

    logic             ptr_we, bank_we, evt_fire, evt_rd_d;
    logic [PTR_W-1:0] ptr_wdata, ptr_cur, ptr_inc, evt_addr_d;
    logic [7:0]       evt_data_d, rx_byte, rx_addr, rd_cur, rd_nxt;
    logic [2:0]       bit_idx;
    logic             addr_hit;

    assign rx_byte  = {sh_q[6:0], sda};
    assign rx_addr  = {1'b0, rx_byte[7:1]};
    assign addr_hit = (rx_addr >= ADDR_LO) && (rx_addr < ADDR_END);
    assign ptr_cur  = ptr_q[ch_q];
    assign ptr_inc  = ptr_cur + PTR_W'(1);
    assign rd_cur   = bank[ch_q][ptr_cur];
    assign rd_nxt   = bank[ch_q][ptr_inc];
    assign bit_idx  = 3'd7 - cnt_q[2:0];

    always_comb begin
        state_d    = state_q;
        oe_d       = oe_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        ack_on_d   = ack_on_q;
        ch_d       = ch_q;
        rw_d       = rw_q;
        ptr_we     = 1'b0;
        ptr_wdata  = ptr_inc;
        bank_we    = 1'b0;
        evt_fire   = 1'b0;
        evt_rd_d   = 1'b0;
        evt_addr_d = ptr_cur;
        evt_data_d = rx_byte;

        if (start_det) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            oe_d     = 1'b0;
            ack_on_d = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            oe_d     = 1'b0;
            ack_on_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    sh_d  = rx_byte;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        rw_d     = rx_byte[0];
                        ch_d     = CH_W'(rx_byte[7:1] - BASE_ADDR);
                        ack_on_d = 1'b0;
                        state_d  = addr_hit ? ADDR_ACK : IGNORE;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!ack_on_q) begin
                        oe_d     = 1'b1;
                        ack_on_d = 1'b1;
                    end else begin
                        // End of the 9th clock: release ACK, or go straight
                        // to driving the first read bit.
                        ack_on_d = 1'b0;
                        cnt_d    = 4'd0;
                        if (rw_q) begin
                            sh_d    = rd_cur;
                            oe_d    = ~rd_cur[7];
                            state_d = RD_BYTE;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = PTR_BYTE;
                        end
                    end
                end
                PTR_BYTE: if (scl_rise) begin
                    sh_d  = rx_byte;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        if ({1'b0, rx_byte} < 9'(DEPTH)) begin
                            ptr_we    = 1'b1;
                            ptr_wdata = PTR_W'(rx_byte);
                            ack_on_d  = 1'b0;
                            state_d   = DATA_ACK;
                        end else begin
                            state_d   = IGNORE;
                        end
                    end
                end
                DATA_ACK: if (scl_fall) begin
                    if (!ack_on_q) begin
                        oe_d     = 1'b1;
                        ack_on_d = 1'b1;
                    end else begin
                        oe_d     = 1'b0;
                        ack_on_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = WR_BYTE;
                    end
                end
                WR_BYTE: if (scl_rise) begin
                    sh_d  = rx_byte;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        bank_we  = 1'b1;
                        evt_fire = 1'b1;
                        ptr_we   = 1'b1;
                        ack_on_d = 1'b0;
                        state_d  = DATA_ACK;
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = RD_ACK;
                        end else begin
                            oe_d = ~sh_q[bit_idx];
                        end
                    end
                end
                RD_ACK: if (scl_rise) begin
                    evt_fire   = 1'b1;
                    evt_rd_d   = 1'b1;
                    evt_data_d = sh_q;
                    ptr_we     = 1'b1;
                    if (!sda) begin
                        sh_d    = rd_nxt;
                        cnt_d   = 4'd0;
                        state_d = RD_BYTE;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                IGNORE:  oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            oe_q        <= 1'b0;
            cnt_q       <= 4'd0;
            sh_q        <= 8'd0;
            ack_on_q    <= 1'b0;
            ch_q        <= '0;
            rw_q        <= 1'b0;
            evt_valid_o <= 1'b0;
            evt_rd_o    <= 1'b0;
            evt_ch_o    <= '0;
            evt_addr_o  <= '0;
            evt_data_o  <= 8'd0;
            for (int i = 0; i < NUM_CH; i++) ptr_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            oe_q        <= oe_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            ack_on_q    <= ack_on_d;
            ch_q        <= ch_d;
            rw_q        <= rw_d;
            evt_valid_o <= evt_fire;
            if (evt_fire) begin
                evt_rd_o   <= evt_rd_d;
                evt_ch_o   <= ch_q;
                evt_addr_o <= evt_addr_d;
                evt_data_o <= evt_data_d;
            end
            if (ptr_we) ptr_q[ch_q] <= ptr_wdata;
        end
    end

    // Bank contents survive reset. The bus write is issued last so it wins
    // a same-cycle collision with the host.
    always_ff @(posedge clk_i) begin
        if (host_we_i && (int'(host_ch_i) < NUM_CH))
            bank[host_ch_i][host_addr_i] <= host_wdata_i;
        if (bank_we)
            bank[ch_q][ptr_cur] <= rx_byte;
    end

    assign sda_oe_o = oe_q;
    assign busy_o   = (state_q != IDLE);

endmodule

// File: doc/i2c_target_multi.md
Name: i2c_target_multi

Overview:
- Synthesisable, parametrised I2C target (slave). It answers NUM_CH consecutive 7-bit addresses; each address is a channel with its own byte register bank of DEPTH entries and its own auto-incrementing pointer.
- Supports write, read, repeated START and pointer persistence across transactions.
- Used as the bus-side responder that the i2c_pkg agents and the IICMB master are checked against.
- A host-side port preloads bank contents; an event port reports every completed byte.

Parameters:
- BASE_ADDR, 7'h22, first responding 7-bit address. Channel c answers BASE_ADDR+c. BASE_ADDR+NUM_CH-1 must be ≤ 7'h7F.
- NUM_CH, 4, number of channels/addresses (1..16).
- DEPTH, 16, bytes per bank; power of two, 2..256. PTR_W = log2(DEPTH).

Ports:
- clk_i  in  1  system clock, ≥ 16x SCL frequency
- rst_i  in  1  asynchronous, active-high reset
- scl_i  in  1  bus SCL (raw, asynchronous)
- sda_i  in  1  bus SDA (raw, asynchronous)
- sda_oe_o  out  1  1 = pull SDA low; 0 = release
- host_we_i  in  1  host bank write strobe
- host_ch_i  in  log2(NUM_CH)  host channel select
- host_addr_i  in  PTR_W  host bank index
- host_wdata_i  in  8  host write data
- evt_valid_o  out  1  one-cycle pulse per completed data byte
- evt_rd_o  out  1  1 = byte was read by master; 0 = written
- evt_ch_o  out  log2(NUM_CH)  channel of event
- evt_addr_o  out  PTR_W  bank index of event
- evt_data_o  out  8  byte transferred
- busy_o  out  1  1 between a START and the next STOP

Behaviour:
- Reset (async assert; released synchronously by the flops): sda_oe_o=0, evt_valid_o=0, evt_*=0, busy_o=0, state IDLE, all pointers=0. Bank contents are not reset.
- Inputs: scl_i and sda_i each pass through a 2-flop synchroniser, then a delay flop for edge detection.
- Bus conditions:
  - START/Sr = synchronised SDA falls while SCL=1. STOP = SDA rises while SCL=1.
  - START/Sr from any state → ADDR, bit counter cleared, busy_o=1, sda_oe_o=0.
  - STOP from any state → IDLE, busy_o=0, sda_oe_o=0.
- Timing: data is sampled on a detected SCL rise. sda_oe_o changes only in the cycle after a detected SCL fall.
- States:
  - ADDR: shift 8 bits, MSB first. Match when address[7:1] is in BASE_ADDR..BASE_ADDR+NUM_CH-1; latch ch = address-BASE_ADDR and rw = bit0. On match → ADDR_ACK. On mismatch → IGNORE (no ACK).
  - ADDR_ACK: drive low for the 9th clock. If rw=0 → PTR_BYTE. If rw=1 → RD_BYTE, loading shift register with bank[ch][ptr[ch]].
  - PTR_BYTE: receive 8 bits.
    - value < DEPTH: ptr[ch]=value, ACK, → WR_BYTE.
    - value ≥ DEPTH: NACK (release), → IGNORE.
  - WR_BYTE: receive 8 bits, write bank[ch][ptr[ch]], ACK, pulse evt (evt_rd_o=0) in the cycle after the 8th sample. Then ptr[ch]=(ptr+1) mod DEPTH, → WR_BYTE.
  - RD_BYTE: drive sda_oe_o = ~bit, MSB first, each bit set after an SCL fall. After the 8th bit, release → RD_ACK.
  - RD_ACK: sample master ACK at SCL rise.
    - Every sampled ACK/NACK pulses evt (evt_rd_o=1, evt_addr_o = old ptr) and advances ptr[ch] mod DEPTH.
    - ACK (0) → load next byte, → RD_BYTE.
    - NACK (1) → IGNORE.
  - IGNORE: sda_oe_o=0, wait for START or STOP.
- Pointer wrap: DEPTH-1 → 0 on write and read, with no NACK.
- Host write and an I2C write to the same bank cell in the same cycle: the I2C write wins. Host writes never affect pointers.
- Reset mid-transfer: sda_oe_o drops asynchronously; the block re-arms only on the next START.

Test Plan:
- Reset while a read drives SDA low → sda_oe_o=0 immediately. A later START to 7'h22 gets ACK, and the pointer read-back is 0.
- Write to 7'h23: pointer 8'h05, then bytes A5, 3C → ACKs on all three bytes. bank[1][5]=A5, bank[1][6]=3C. Two evt pulses, ch=1, addr 5 then 6.
- Host preloads bank[2][14]=11, [15]=22, [0]=33. Master does write 7'h24 pointer 0E, Sr, read 3 bytes (ACK, ACK, NACK) → reads 11, 22, 33. Wrap is confirmed; evt_rd_o=1 with addrs 14, 15, 0.
- Address 7'h30 (no match) → no ACK on the 9th clock; sda_oe_o stays 0 until STOP. busy_o=1 between START and STOP.
- Pointer byte 8'h10 with DEPTH=16 → NACK, following data ignored, bank unchanged.
- STOP inserted mid-byte during a write → IDLE, no bank write, no evt. A following read from 7'h25 returns bank[3][ptr[3]] with that channel's pointer unchanged.
